// File: rtl/cgra_config_loader_if.sv
// Configuration word stream between a bitstream source and the config loader.
interface cgra_config_loader_if #(
  parameter int size = 32
);
  logic [size-1:0] cfg_word;
  logic            cfg_valid;
  logic            cfg_ready;

  modport master (
    output cfg_word,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_word,
    input  cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/cgra_config_loader.sv
// Serialises configuration words LSB-first into a PE config chain after a
// config_reset clear pulse; exactly CHAIN_LEN bits are shifted per load.
module cgra_config_loader #(
  parameter int size       = 32,
  parameter int CHAIN_LEN  = 64,
  parameter int CLR_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  cgra_config_loader_if.slave  cfg,
  output logic                 config_reset,
  output logic                 config_out,
  output logic                 config_shift,
  output logic                 busy,
  output logic                 done
);
  localparam int CNT_W = $clog2(size + 1);
  localparam int REM_W = $clog2(CHAIN_LEN + 1);
  localparam int CLR_W = $clog2(CLR_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} state_t;

  state_t           state, state_nxt;
  logic [size-1:0]  sr, sr_nxt;
  logic [CNT_W-1:0] sr_cnt, sr_cnt_nxt;
  logic [REM_W-1:0] rem, rem_nxt;
  logic [CLR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic             shift_en;
  logic             accept;
  logic             shifting_nxt;

  // Refill is offered while the last buffered bit drains, but never beyond the chain length.
  assign cfg.cfg_ready = (state == LOAD) && (sr_cnt <= CNT_W'(1)) && (32'(rem) > 32'(sr_cnt));

  always_comb begin
    state_nxt   = state;
    sr_nxt      = sr;
    sr_cnt_nxt  = sr_cnt;
    rem_nxt     = rem;
    clr_cnt_nxt = clr_cnt;
    shift_en    = 1'b0;
    accept      = 1'b0;
    if (start) begin
      state_nxt   = CLEAR;
      sr_nxt      = '0;
      sr_cnt_nxt  = '0;
      rem_nxt     = REM_W'(CHAIN_LEN);
      clr_cnt_nxt = CLR_W'(CLR_CYCLES);
    end else begin
      unique case (state)
        IDLE, DONE: begin
        end
        CLEAR: begin
          clr_cnt_nxt = clr_cnt - CLR_W'(1);
          if (clr_cnt <= CLR_W'(1)) begin
            state_nxt   = LOAD;
            clr_cnt_nxt = '0;
          end
        end
        LOAD: begin
          shift_en = (sr_cnt != '0);
          accept   = cfg.cfg_ready && cfg.cfg_valid;
          if (shift_en) begin
            sr_nxt     = sr >> 1;
            sr_cnt_nxt = sr_cnt - CNT_W'(1);
            rem_nxt    = rem - REM_W'(1);
          end
          // A new word overrides the drained register in the same cycle.
          if (accept) begin
            sr_nxt     = cfg.cfg_word;
            sr_cnt_nxt = CNT_W'(size);
          end
          if (shift_en && (rem == REM_W'(1))) begin
            state_nxt  = DONE;
            sr_nxt     = '0;
            sr_cnt_nxt = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are registered from next-state so they describe the current cycle's shift.
  assign shifting_nxt = (state_nxt == LOAD) && (sr_cnt_nxt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sr           <= '0;
      sr_cnt       <= '0;
      rem          <= '0;
      clr_cnt      <= '0;
      config_reset <= 1'b0;
      config_out   <= 1'b0;
      config_shift <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      sr           <= sr_nxt;
      sr_cnt       <= sr_cnt_nxt;
      rem          <= rem_nxt;
      clr_cnt      <= clr_cnt_nxt;
      config_reset <= (state_nxt == CLEAR);
      config_out   <= shifting_nxt & sr_nxt[0];
      config_shift <= shifting_nxt;
      busy         <= (state_nxt == CLEAR) || (state_nxt == LOAD);
      done         <= (state_nxt == DONE);
    end
  end
endmodule

// File: tb/tb_cgra_config_loader.sv
// Bench for cgra_config_loader: four instances with CHAIN_LEN 40/64/32/1, a bit
// scoreboard on config_out, and per-load timing/count checks.
module tb_cgra_config_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  start_v, valid_v, ready_v, creset_v, out_v, shift_v, busy_v, done_v;
  logic [31:0] word_a [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    cgra_config_loader_if #(.size(32)) ifc ();
    assign ifc.cfg_word  = word_a[g];
    assign ifc.cfg_valid = valid_v[g];
    assign ready_v[g]    = ifc.cfg_ready;

    cgra_config_loader #(
      .size      (32),
      .CHAIN_LEN ((g == 0) ? 40 : (g == 1) ? 64 : (g == 2) ? 32 : 1),
      .CLR_CYCLES(2)
    ) dut (
      .clk         (clk),
      .reset       (rst),
      .start       (start_v[g]),
      .cfg         (ifc),
      .config_reset(creset_v[g]),
      .config_out  (out_v[g]),
      .config_shift(shift_v[g]),
      .busy        (busy_v[g]),
      .done        (done_v[g])
    );
  end

  typedef struct {
    int          dut;
    logic [31:0] w0, w1, w2;
    int          stall;
    int          exp_shifts;
    int          exp_bubbles;
    int          exp_acc;
    int          exp_ready;
    int          exp_done;
  } vec_t;

  vec_t        tbl [6];
  int          checks = 0, failures = 0;
  int          sel = 0, cyc = 0;
  int          shift_cnt = 0, bubble_cnt = 0, ready_cnt = 0, accept_cnt = 0, creset_cnt = 0;
  int          start_cyc = 0, creset_first = -1, ready_first = -1, done_cyc = -1;
  int          push_rem = 0, stall_len = 0, stall_cnt = 0;
  logic        acc_flag = 1'b0;
  logic        eb;
  logic        exp_q [$];
  logic [31:0] src_q [$];

  function automatic int cl_of(input int d);
    case (d)
      0:       return 40;
      1:       return 64;
      2:       return 32;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Scoreboard: expected bits queued at accept, popped on every config_shift.
  always @(negedge clk) begin
    cyc++;
    if (shift_v[sel]) begin
      shift_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL config_out_extra: shift %0d seen on dut %0d, required no shift", shift_cnt, sel);
      end else begin
        eb = exp_q.pop_front();
        chk($sformatf("config_out_bit%0d", shift_cnt - 1), 64'(out_v[sel]), 64'(eb));
      end
    end
    if (rst || start_v[sel]) begin
      exp_q.delete();
      push_rem     = cl_of(sel);
      shift_cnt    = 0;
      bubble_cnt   = 0;
      ready_cnt    = 0;
      accept_cnt   = 0;
      creset_cnt   = 0;
      creset_first = -1;
      ready_first  = -1;
      done_cyc     = -1;
      start_cyc    = cyc;
      stall_cnt    = 0;
      acc_flag     = 1'b0;
    end else begin
      if (busy_v[sel] && !creset_v[sel] && !shift_v[sel] && shift_cnt > 0) bubble_cnt++;
      if (ready_v[sel]) begin
        ready_cnt++;
        if (ready_first < 0) ready_first = cyc;
      end
      if (creset_v[sel]) begin
        creset_cnt++;
        if (creset_first < 0) creset_first = cyc;
      end
      if (done_v[sel] && done_cyc < 0) done_cyc = cyc;
      if (valid_v[sel] && ready_v[sel]) begin
        accept_cnt++;
        acc_flag = 1'b1;
        for (int k = 0; k < 32; k++) begin
          if (push_rem > 0) begin
            exp_q.push_back(word_a[sel][k]);
            push_rem--;
          end
        end
        if (accept_cnt == 1) stall_cnt = stall_len;
      end else if (ready_v[sel] && !valid_v[sel] && stall_cnt > 0) begin
        stall_cnt--;
      end
    end
  end

  task automatic drive_feed();
    valid_v = '0;
    for (int d = 0; d < 4; d++) word_a[d] = '0;
    if (src_q.size() > 0 && stall_cnt == 0) begin
      valid_v[sel] = 1'b1;
      word_a[sel]  = src_q[0];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    start_v = '0;
    if (acc_flag) begin
      acc_flag = 1'b0;
      if (src_q.size() > 0) src_q.delete(0);
    end
    drive_feed();
  endtask

  task automatic start_load(input int r);
    sel       = tbl[r].dut;
    stall_len = tbl[r].stall;
    stall_cnt = 0;
    acc_flag  = 1'b0;
    src_q.delete();
    src_q.push_back(tbl[r].w0);
    src_q.push_back(tbl[r].w1);
    src_q.push_back(tbl[r].w2);
    start_v      = '0;
    start_v[sel] = 1'b1;
    drive_feed();
    step();
    chk($sformatf("r%0d_start_creset", r), 64'(creset_v[sel]), 1);
    chk($sformatf("r%0d_start_busy", r), 64'(busy_v[sel]), 1);
    chk($sformatf("r%0d_start_done_clr", r), 64'(done_v[sel]), 0);
    chk($sformatf("r%0d_start_no_shift", r), 64'(shift_v[sel]), 0);
  endtask

  task automatic finish_load(input int r);
    for (int i = 0; i < 400 && done_cyc < 0; i++) step();
    chk($sformatf("r%0d_done_seen", r), 64'(done_cyc >= 0), 1);
    repeat (5) step();
    chk($sformatf("r%0d_shifts", r), shift_cnt, tbl[r].exp_shifts);
    chk($sformatf("r%0d_bubbles", r), bubble_cnt, tbl[r].exp_bubbles);
    chk($sformatf("r%0d_accepts", r), accept_cnt, tbl[r].exp_acc);
    chk($sformatf("r%0d_ready_cycles", r), ready_cnt, tbl[r].exp_ready);
    chk($sformatf("r%0d_done_latency", r), done_cyc - start_cyc, tbl[r].exp_done);
    chk($sformatf("r%0d_creset_len", r), creset_cnt, 2);
    chk($sformatf("r%0d_creset_first", r), creset_first - start_cyc, 1);
    chk($sformatf("r%0d_ready_first", r), ready_first - start_cyc, 3);
    chk($sformatf("r%0d_bits_left", r), exp_q.size(), 0);
    chk($sformatf("r%0d_done_hold", r), 64'(done_v[sel]), 1);
    chk($sformatf("r%0d_busy_end", r), 64'(busy_v[sel]), 0);
  endtask

  initial begin
    //           dut  w0            w1            w2            stall shifts bub acc rdy done
    tbl[0] = '{0, 32'hA5A5_A5A5, 32'h0000_00F0, 32'h5A5A_5A5A, 0, 40, 0, 2, 2, 44};
    tbl[1] = '{1, 32'hC3C3_0F0F, 32'h1234_ABCD, 32'hFFFF_FFFF, 5, 64, 5, 2, 7, 73};
    tbl[2] = '{1, 32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFF_FFFF, 0, 64, 0, 2, 2, 68};
    tbl[3] = '{2, 32'hDEAD_BEEF, 32'h1111_1111, 32'h2222_2222, 0, 32, 0, 1, 1, 36};
    tbl[4] = '{3, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,  1, 0, 1, 1,  5};
    tbl[5] = '{0, 32'hA5A5_A5A5, 32'h0000_00F0, 32'h5A5A_5A5A, 0, 40, 0, 2, 2, 44};

    rst     = 1'b1;
    start_v = '0;
    valid_v = '0;
    for (int d = 0; d < 4; d++) word_a[d] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst%0d_ready", d), 64'(ready_v[d]), 0);
      chk($sformatf("rst%0d_creset", d), 64'(creset_v[d]), 0);
      chk($sformatf("rst%0d_out", d), 64'(out_v[d]), 0);
      chk($sformatf("rst%0d_shift", d), 64'(shift_v[d]), 0);
      chk($sformatf("rst%0d_busy", d), 64'(busy_v[d]), 0);
      chk($sformatf("rst%0d_done", d), 64'(done_v[d]), 0);
    end
    rst = 1'b0;
    step();

    for (int r = 0; r < 6; r++) begin
      start_load(r);
      finish_load(r);
    end

    // Abort after 10 shifts and restart from the first word.
    start_load(2);
    for (int i = 0; i < 200 && shift_cnt < 10; i++) step();
    chk("abort_pre_shifts", shift_cnt, 10);
    start_load(2);
    finish_load(2);

    // Reset in the middle of LOAD, then a clean full load.
    start_load(2);
    for (int i = 0; i < 200 && shift_cnt < 20; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_creset", 64'(creset_v[1]), 0);
    chk("midrst_out", 64'(out_v[1]), 0);
    chk("midrst_shift", 64'(shift_v[1]), 0);
    chk("midrst_busy", 64'(busy_v[1]), 0);
    chk("midrst_done", 64'(done_v[1]), 0);
    chk("midrst_ready", 64'(ready_v[1]), 0);
    step();
    chk("midrst_idle_ready", 64'(ready_v[1]), 0);
    chk("midrst_idle_busy", 64'(busy_v[1]), 0);
    chk("midrst_idle_creset", 64'(creset_v[1]), 0);
    start_load(2);
    finish_load(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cgra_config_loader.md
# cgra_config_loader

Bitstream loader that sits directly upstream of a PE block's configuration chain. It accepts configuration words over a valid/ready stream and clears the chain with a `config_reset` pulse. It then shifts exactly `CHAIN_LEN` bits, LSB-first, into the chain's serial `config_in`, with one bit and one `config_shift` strobe per cycle. `config_shift` is the enable the fabric clock gate uses to produce `config_clk` edges.

## Interface
Parameters:
- `size`, default 32: configuration word width in bits.
- `CHAIN_LEN`, default 64: total bits in the downstream config chain (≥1).
- `CLR_CYCLES`, default 2: length of the `config_reset` pulse in cycles (≥1).

Ports:
- `clk`  in  1: the single clock; all state is updated on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle request to begin a full load; honoured in any state.
- `cfg_word`  in  size: configuration word; bit 0 is shifted first.
- `cfg_valid`  in  1: `cfg_word` is valid.
- `cfg_ready`  out  1: the loader accepts the word this cycle when `cfg_valid` is also high.
- `config_reset`  out  1: clear pulse to the chain.
- `config_out`  out  1: serial bit driving the chain's `config_in`.
- `config_shift`  out  1: qualifies `config_out`; one chain shift occurs per high cycle.
- `busy`  out  1: high from the cycle after `start` until done.
- `done`  out  1: sticky completion flag, cleared by `start` or `reset`.

## Operation
- **Registers**
  - Shift register `sr[size-1:0]`.
  - Valid-bit count `sr_cnt`, range 0..size.
  - Remaining-bit counter `rem`, $clog2(CHAIN_LEN+1) bits wide, holding CHAIN_LEN..0.
  - Clear counter and a 2-bit state.
- **States:** IDLE, CLEAR, LOAD, DONE.
- **IDLE**
  - All outputs are 0 except `cfg_ready`=0.
  - `start` loads `rem`=CHAIN_LEN and the clear counter=CLR_CYCLES, and moves to CLEAR.
- **CLEAR**
  - `config_reset`=1 for exactly CLR_CYCLES cycles, then move to LOAD.
  - `cfg_ready`=0 throughout.
- **LOAD**
  - `cfg_ready` = (`sr_cnt`==0 or `sr_cnt`==1) and `rem` > `sr_cnt`. This gives a zero-bubble refill on the last bit of a word.
  - An accepted word loads `sr`=`cfg_word` and `sr_cnt`=size. If the final bit of the previous word shifts in the same cycle, the new load takes priority after that shift.
  - Each cycle with `sr_cnt`>0: `config_out`=`sr[0]` and `config_shift`=1. Then `sr` shifts right by one, `sr_cnt` decrements and `rem` decrements.
  - When the shift that takes `rem` to 0 completes, move to DONE. Any unused high bits of the final word are discarded.
  - `config_shift`=0 in cycles where `sr_cnt`==0, which are bubbles caused by upstream starvation. No shift occurs in those cycles.
- **DONE**
  - `done`=1, `busy`=0, `cfg_ready`=0.
  - `start` re-enters CLEAR and clears `done`.
- **Word count:** exactly ceil(CHAIN_LEN/size) words are accepted per load. No extra word is ever accepted.
- **`start` while in CLEAR or LOAD:** abort and restart.
  - `sr_cnt`=0, `rem`=CHAIN_LEN, and re-enter CLEAR.
  - No shift occurs in the `start` cycle.
  - A word offered in that cycle is not accepted.
- **`reset`:** has priority over everything else.
  - Next state is IDLE; `sr`, `sr_cnt`, `rem` and all outputs go to 0.
  - A load interrupted mid-operation is never resumed.

## Timing
- Outputs are registered except `cfg_ready`, which is a combinational decode of registered state only. It never depends on `cfg_valid`.
- **Reset values:** `cfg_ready`=0, `config_reset`=0, `config_out`=0, `config_shift`=0, `busy`=0, `done`=0.
- **Start sequence:**
  - `start` sampled at cycle t: `config_reset`=1 and `busy`=1 in cycles t+1..t+CLR_CYCLES.
  - `cfg_ready` can first be 1 in cycle t+CLR_CYCLES+1.
- **Word latency:** a word accepted at cycle a produces its bit 0 on `config_out`, with `config_shift`=1, in cycle a+1. Bit k appears at a+1+k if there are no stalls.
- **Streaming:** with `cfg_valid` held high, `config_shift` is high for CHAIN_LEN consecutive cycles.
- **Completion:** `done` rises, and `busy` falls, the cycle after the final shift.
- **Minimum total load time:** 1 + CLR_CYCLES + 1 + CHAIN_LEN cycles from `start` to `done`.

## Test plan
- **Streaming load:** CHAIN_LEN=40, size=32, CLR_CYCLES=2; `start`, then words 0xA5A5A5A5 and 0x000000F0 with `cfg_valid` held high.
  - `config_reset` high for 2 cycles.
  - 40 consecutive shifts: bits 0..31 of word 0, then bits 0..7 of word 1 (00001111 as 0,0,0,0,1,1,1,1).
  - A third word is never accepted; `done`=1 at cycle 1+2+1+40 after `start`.
- **Starvation:** CHAIN_LEN=64; drop `cfg_valid` for 5 cycles between the two words.
  - Exactly 5 `config_shift`=0 bubbles, 64 total shifts, bitstream identical to the stall-free run.
- **Abort:** `start` asserted again after 10 shifts.
  - The next cycle has `config_reset`=1 and `config_shift`=0.
  - Then a full CHAIN_LEN shifts from the first word; `done` does not assert early.
- **Reset mid-load:** `reset` asserted during LOAD.
  - The next cycle shows all outputs 0 and the loader in IDLE.
  - A later `start` performs a complete, correct load.
- **Exact-multiple boundary:** CHAIN_LEN=32, size=32, then CHAIN_LEN=1.
  - One word accepted in each case; 32 shifts and 1 shift respectively.
  - `cfg_ready` stays 0 after the single accept.
- **Restart from DONE:** `start` while `done`=1.
  - `done` clears the next cycle and the sequence repeats with identical timing.
